// File: rtl/pkt_comm_pkg.sv
// Shared definitions for the packet-communication blocks: arbiter state
// encoding, default packet length limit and a constant-width helper.
package pkt_comm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ERR  = 2'd2
    } arb_state_t;

    localparam int MAX_PKT_WORDS_DEFAULT = 1024;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Index widths must stay at least one bit even for a single source.
    function automatic int width_of(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin first-valid search: lowest request index at or after ptr,
// wrapping from N-1 back to 0.
module rr_select
    import pkt_comm_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = width_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    int cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/outpkt_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC result sources into one
// output FIFO, with a sticky error for packets exceeding MAX_PKT_WORDS.
module outpkt_arbiter
    import pkt_comm_pkg::*;
#(
    parameter int N_SRC         = 4,
    parameter int WIDTH         = 16,
    parameter int MAX_PKT_WORDS = MAX_PKT_WORDS_DEFAULT
) (
    input  logic                      PKT_COMM_CLK,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*WIDTH-1:0]    src_data,
    input  logic [N_SRC-1:0]          src_last,
    output logic [N_SRC-1:0]          src_rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      wr_en,
    input  logic                      full,
    output logic [width_of(N_SRC)-1:0] grant,
    output logic                      busy,
    output logic                      err
);

    localparam int GW = width_of(N_SRC);
    localparam int CW = clog2(MAX_PKT_WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PKT_WORDS - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [GW-1:0] ptr;
    logic [GW-1:0] sel_idx;
    logic          sel_found;
    logic          start;
    logic          xfer_go;
    logic [CW-1:0] word_cnt;

    rr_select #(.N(N_SRC), .IW(GW)) u_rr_select (
        .req   (src_valid),
        .ptr   (ptr),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign start   = (state == ST_IDLE) && en && sel_found;
    assign xfer_go = (state == ST_XFER) && src_valid[grant] && !full;

    always_ff @(posedge PKT_COMM_CLK or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Once granted, en is ignored: a packet always runs to its last word.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_XFER;
            ST_XFER: begin
                if (xfer_go) begin
                    if (src_last[grant])          state_nxt = ST_IDLE;
                    else if (word_cnt == LAST_CNT) state_nxt = ST_ERR;
                end
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en     = xfer_go;
        src_rd_en = '0;
        if (xfer_go) src_rd_en[grant] = 1'b1;
        busy      = (state == ST_XFER);
        dout      = src_data[int'(grant)*WIDTH +: WIDTH];
    end

    // A last word landing exactly on the limit is legal, so last wins over the count.
    always_ff @(posedge PKT_COMM_CLK or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            grant    <= '0;
            word_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (start) begin
                grant    <= sel_idx;
                word_cnt <= '0;
            end
            if (xfer_go) begin
                word_cnt <= word_cnt + 1'b1;
                if (src_last[grant])
                    ptr <= (int'(grant) == N_SRC - 1) ? '0 : grant + 1'b1;
                else if (word_cnt == LAST_CNT)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_outpkt_arbiter.sv
// Bench for outpkt_arbiter: queue-modelled sources, scoreboard of expected
// output words, table-driven arbitration scenarios plus corner sequences.
module tb_outpkt_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MAXW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            full;
    logic [N-1:0]    src_valid;
    logic [N*W-1:0]  src_data;
    logic [N-1:0]    src_last;
    logic [N-1:0]    src_rd_en;
    logic [W-1:0]    dout;
    logic            wr_en;
    logic [1:0]      grant;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    outpkt_arbiter #(.N_SRC(N), .WIDTH(W), .MAX_PKT_WORDS(MAXW)) dut (
        .PKT_COMM_CLK (clk),
        .rst          (rst),
        .en           (en),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_rd_en    (src_rd_en),
        .dout         (dout),
        .wr_en        (wr_en),
        .full         (full),
        .grant        (grant),
        .busy         (busy),
        .err          (err)
    );

    logic [16:0] srcq [N][$];
    logic [15:0] sbq [$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          nwr      = 0;
    int          first_wr = -1;
    int          last_wr  = -1;
    logic [N-1:0] rd_lat;
    bit          toggle_full = 1'b0;

    typedef struct {
        logic [3:0] mask;
        int         npk;
        int         len;
        int         ord[8];
        int         nord;
        int         span;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [15:0] mkw(input int s, input int p, input int i);
        return {4'(s), 4'(p), 8'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                src_valid[i]         = 1'b1;
                src_data[i*W +: W]   = srcq[i][0][15:0];
                src_last[i]          = srcq[i][0][16];
            end else begin
                src_valid[i]         = 1'b0;
                src_data[i*W +: W]   = '0;
                src_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic load_pkt(input int s, input int p, input int len, input bit with_last);
        for (int i = 0; i < len; i++)
            srcq[s].push_back({with_last && (i == len - 1), mkw(s, p, i)});
    endtask

    task automatic expect_pkt(input int s, input int p, input int len);
        for (int i = 0; i < len; i++) sbq.push_back(mkw(s, p, i));
    endtask

    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        if (full) chk("rd_while_full", 32'(src_rd_en), 32'd0);
        if (wr_en) begin
            nwr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: dout %0h grant %0d, required no write", dout, grant);
            end else begin
                e = sbq.pop_front();
                chk("dout", 32'(dout), 32'(e));
                chk("grant", 32'(grant), 32'(e[15:12]));
                chk("src_rd_en", 32'(src_rd_en), 32'(4'b0001 << e[15:12]));
                chk("busy_at_write", 32'(busy), 32'd1);
            end
        end else begin
            chk("rd_without_wr", 32'(src_rd_en), 32'd0);
        end
        rd_lat = src_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (rd_lat[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (toggle_full) full = ~full;
        present();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words left, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int pc[N];
        int base;
        int n;

        rst = 1'b1; en = 1'b0; full = 1'b0;
        src_valid = '0; src_data = '0; src_last = '0; rd_lat = '0;
        repeat (2) @(posedge clk);
        #1;
        src_valid = 4'hF;
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_rd_en", 32'(src_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        present();
        en = 1'b1;

        vecs[0] = '{4'b1111, 2, 2, '{0, 1, 2, 3, 0, 1, 2, 3}, 8, 23};
        vecs[1] = '{4'b0101, 1, 3, '{0, 2, 0, 0, 0, 0, 0, 0}, 2, 7};
        vecs[2] = '{4'b1001, 1, 2, '{3, 0, 0, 0, 0, 0, 0, 0}, 2, 5};
        vecs[3] = '{4'b0100, 1, 1, '{2, 0, 0, 0, 0, 0, 0, 0}, 1, 1};

        for (int v = 0; v < 4; v++) begin
            for (int s = 0; s < N; s++) pc[s] = 0;
            for (int p = 0; p < vecs[v].npk; p++)
                for (int s = 0; s < N; s++)
                    if (vecs[v].mask[s]) load_pkt(s, p, vecs[v].len, 1'b1);
            for (int k = 0; k < vecs[v].nord; k++) begin
                expect_pkt(vecs[v].ord[k], pc[vecs[v].ord[k]], vecs[v].len);
                pc[vecs[v].ord[k]]++;
            end
            present();
            first_wr = -1;
            last_wr  = -1;
            drain(200);
            chk($sformatf("span_vec%0d", v), 32'(last_wr - first_wr + 1), 32'(vecs[v].span));
            chk($sformatf("busy_after_vec%0d", v), 32'(busy), 32'd0);
        end

        // en low: a waiting source must not be granted; grant keeps last value.
        en = 1'b0;
        load_pkt(1, 0, 2, 1'b1);
        present();
        repeat (6) tick();
        chk("en0_busy", 32'(busy), 32'd0);
        chk("en0_grant_held", 32'(grant), 32'd2);
        en = 1'b1;
        expect_pkt(1, 0, 2);
        drain(50);

        // Output FIFO full on alternate cycles during a 5-word packet.
        toggle_full = 1'b1;
        load_pkt(2, 0, 5, 1'b1);
        expect_pkt(2, 0, 5);
        present();
        base = nwr;
        drain(100);
        toggle_full = 1'b0;
        full = 1'b0;
        chk("full_toggle_writes", 32'(nwr - base), 32'd5);

        // en dropped after the second word: packet still completes.
        load_pkt(3, 0, 4, 1'b1);
        load_pkt(0, 1, 1, 1'b1);
        expect_pkt(3, 0, 4);
        present();
        base = nwr;
        n = 0;
        while (nwr - base < 2 && n < 50) begin
            tick();
            n++;
        end
        en = 1'b0;
        drain(50);
        chk("en_drop_words", 32'(nwr - base), 32'd4);
        repeat (8) tick();
        chk("en_drop_no_grant", 32'(nwr - base), 32'd4);
        chk("en_drop_busy", 32'(busy), 32'd0);
        en = 1'b1;
        expect_pkt(0, 1, 1);
        drain(50);

        // Length limit: last on the 8th word is legal, a 9th word is not.
        load_pkt(1, 2, 8, 1'b1);
        expect_pkt(1, 2, 8);
        present();
        drain(100);
        chk("max_exact_err", 32'(err), 32'd0);
        load_pkt(2, 3, 9, 1'b0);
        expect_pkt(2, 3, 8);
        present();
        drain(100);
        chk("oversize_err", 32'(err), 32'd1);
        repeat (6) tick();
        chk("oversize_err_sticky", 32'(err), 32'd1);
        chk("oversize_busy", 32'(busy), 32'd0);
        chk("oversize_word_left", 32'(srcq[2].size()), 32'd1);

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("err_cleared_by_rst", 32'(err), 32'd0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        present();
        @(negedge clk);
        rst = 1'b0;

        load_pkt(2, 4, 1, 1'b1);
        expect_pkt(2, 4, 1);
        present();
        drain(50);

        // Asynchronous reset in the middle of a packet.
        load_pkt(3, 5, 6, 1'b1);
        expect_pkt(3, 5, 6);
        present();
        base = nwr;
        n = 0;
        while (nwr - base < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_rd_en", 32'(src_rd_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        sbq.delete();
        present();
        @(negedge clk);
        rst = 1'b0;

        load_pkt(3, 6, 1, 1'b1);
        load_pkt(0, 6, 1, 1'b1);
        expect_pkt(0, 6, 1);
        expect_pkt(3, 6, 1);
        present();
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/outpkt_arbiter.md
OUTPKT_ARBITER -- requirements
Module: outpkt_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning number of result sources sharing the output FIFO.
REQ-002 SHALL have parameter WIDTH, default 16, meaning the data word width (matches output FIFO din).
REQ-003 SHALL have parameter MAX_PKT_WORDS, default 1024, meaning the maximum legal packet length in words.
REQ-004 SHALL have port PKT_COMM_CLK, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, grant enable (from app_mode); low blocks new grants only.
REQ-007 SHALL have port src_valid, input, N_SRC, meaning source i has a word available.
REQ-008 SHALL have port src_data, input, N_SRC*WIDTH, meaning source i word in bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port src_last, input, N_SRC, meaning the presented word is the last of its packet.
REQ-010 SHALL have port src_rd_en, input-side pop, output, N_SRC, meaning source i word consumed this cycle.
REQ-011 SHALL have port dout, output, WIDTH, meaning the word to the output FIFO.
REQ-012 SHALL have port wr_en, output, 1, meaning the output FIFO write strobe.
REQ-013 SHALL have port full, input, 1, meaning the output FIFO is full.
REQ-014 SHALL have port grant, output, clog2(N_SRC), meaning the currently or last granted source.
REQ-015 SHALL have port busy, output, 1, meaning a packet transfer is in progress.
REQ-016 SHALL have port err, output, 1, sticky oversize-packet error (feeds pkt_comm_status).

Function
REQ-017 SHALL implement states IDLE, XFER and ERR.
REQ-018 In IDLE with en=1 and any src_valid bit set, SHALL register grant as the first valid source at or after ptr (round-robin, wrapping N_SRC-1 to 0) and enter XFER on the next edge.
REQ-019 In IDLE with en=0, SHALL stay in IDLE regardless of src_valid.
REQ-020 In XFER, wr_en and src_rd_en[grant] SHALL be combinationally src_valid[grant] & ~full; all other src_rd_en bits SHALL be 0.
REQ-021 dout SHALL be src_data of grant combinationally (zero latency); dout is don't-care when wr_en=0.
REQ-022 With full=1 or src_valid[grant]=0 in XFER, SHALL hold state and the word count with no write.
REQ-023 SHALL count words written per packet in a counter of width clog2(MAX_PKT_WORDS+1), cleared on entering XFER.
REQ-024 On a write with src_last[grant]=1, SHALL return to IDLE and set ptr to grant+1 modulo N_SRC.
REQ-025 On the MAX_PKT_WORDS-th write of a packet without src_last, SHALL enter ERR and set err=1.
REQ-026 A write with src_last=1 on exactly the MAX_PKT_WORDS-th word SHALL be legal and SHALL NOT raise err.
REQ-027 en falling during XFER SHALL NOT abort the packet; the packet SHALL complete to src_last.
REQ-028 In ERR, wr_en and src_rd_en SHALL be 0 and the state SHALL hold until rst.
REQ-029 busy SHALL be 1 exactly while in XFER.
REQ-030 Arbitration SHALL cost one idle cycle between packets (IDLE->XFER); no write occurs in IDLE.

Reset
REQ-031 rst SHALL asynchronously force state IDLE, ptr=0, grant=0, word count=0, err=0, busy=0.
REQ-032 wr_en and src_rd_en SHALL be 0 while rst is high.
REQ-033 rst asserted mid-packet SHALL drop the packet; sources are reset by the same rst.

Structure
REQ-034 The state encoding and a clog2 helper SHALL live in the shared pkt_comm package; MAX_PKT_WORDS default SHALL be a package constant.
REQ-035 The round-robin first-valid search SHALL be a sub-module rr_select (inputs: request vector, ptr; outputs: index, found).

Verification
REQ-036 Sources 0 and 2 each hold 3-word packets, full=0 -> writes 0,0,0 then one idle cycle then 2,2,2; ptr ends at 3.
REQ-037 All 4 sources continuously valid, 2-word packets -> grant order 0,1,2,3,0 with no source starved.
REQ-038 full toggled high every other cycle during a 5-word packet -> exactly 5 writes, no src_rd_en while full=1, no word lost or duplicated.
REQ-039 en dropped after word 2 of a 4-word packet -> all 4 words written, then no further grants while en=0.
REQ-040 MAX_PKT_WORDS=8: 8 words with last on word 8 -> err=0; 9-word packet -> err=1 after 8th write, wr_en stays 0 until rst.
REQ-041 rst pulsed mid-XFER -> outputs go to reset values asynchronously; next grant after release is source 0.
